display_mux: RTL
================

# display_mux

Drives a 4-digit, common-anode, multiplexed seven-segment display from the four BCD digits produced by the `count` stopwatch block. It sits directly downstream of `count`, takes `min1`, `min0`, `sec1` and `sec0` plus the `adjust`/`select` controls, and scans the digits one at a time. While an adjust mode is active, the selected field (minutes or seconds) blinks. All outputs are registered, with active-low anodes and active-low segments.

## Interface
- `SCAN_DIV`, default 100000: clk cycles per digit slot; 1 kHz digit rate at 100 MHz. Legal range is ≥2.
- `BLINK_TICKS`, default 250: scan ticks per blink half-period; 2 Hz blink at defaults. Legal range is ≥1.
- `clk` input, 1 bit: system clock, rising-edge.
- `reset` input, 1 bit: synchronous, active-high reset.
- `min1` input, 4 bits: tens-of-minutes BCD digit.
- `min0` input, 4 bits: minutes BCD digit.
- `sec1` input, 4 bits: tens-of-seconds BCD digit.
- `sec0` input, 4 bits: seconds BCD digit.
- `adjust` input, 2 bits: nonzero selects adjust mode and enables blinking.
- `select` input, 1 bit: field being adjusted. 0 selects minutes; 1 selects seconds.
- `an` output, 4 bits: anode enables, active-low. Bit 0 is the rightmost digit (`sec0`).
- `seg` output, 7 bits: segments `{g,f,e,d,c,b,a}`, active-low.

## Operation
- **Scan prescaler.** `scan_cnt` counts 0..SCAN_DIV-1 and then wraps. `scan_tick` is asserted in the cycle where `scan_cnt == SCAN_DIV-1`.
- **Digit index.** `idx` is 2 bits and increments modulo 4 on each `scan_tick`. The mapping is:
  - 0: `sec0`, `an=1110`
  - 1: `sec1`, `an=1101`
  - 2: `min0`, `an=1011`
  - 3: `min1`, `an=0111`
- **Decode (active-low, `{g..a}`).**
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Codes 10–15 produce a blank digit: `seg=1111111`, with `an` still driven.
- **Blink counter.**
  - `blink_cnt` counts `scan_tick`s 0..BLINK_TICKS-1. On wrap, `blink_phase` toggles.
  - When `adjust==0`, `blink_cnt` and `blink_phase` are held at 0, so entering adjust mode always starts in the visible phase.
- **Blanking.** When `adjust!=0`, `blink_phase==1`, and the current digit belongs to the selected field, the outputs are forced to `an=1111` and `seg=1111111`.
  - `select=0` blanks idx 2 and 3.
  - `select=1` blanks idx 0 and 1.
- **Input sampling.** Inputs are not latched. Each cycle's outputs use the digit values present in the previous cycle, so a digit change from `count` appears on the next clock edge.
- **Out-of-range controls.** Any nonzero `adjust` value (01, 10 or 11) behaves identically.

## Timing
- **Reset values.** While `reset` is sampled high:
  - `scan_cnt=0`, `idx=0`, `blink_cnt=0`, `blink_phase=0`
  - `an=1111`, `seg=1111111`
- **Output latency.** `an` and `seg` are registered and reflect `idx`, `blink_phase` and the inputs as sampled at the previous edge. Latency is 1 cycle.
- **After reset.** At the first edge with `reset` low, the outputs become `an=1110`, `seg=decode(sec0)`. The digit slot stays for exactly SCAN_DIV cycles, and every later slot is also exactly SCAN_DIV cycles.
- **Slot-to-slot transition.** The anode never overlaps: exactly one `an` bit is low per cycle unless the digit is blanked. Ghosting suppression is out of scope.
- **Blink period.** The blink half-period is SCAN_DIV·BLINK_TICKS cycles. `blink_phase` toggles in the same cycle as the wrapping `scan_tick`.
- **Adjust deasserted mid-blank.** When `adjust` falls to 0 during a blanked phase, the next cycle's outputs are unblanked and `blink_phase` is cleared in that same edge.
- **Reset mid-scan.** Reset mid-scan returns to the reset values on that edge, regardless of counter state.
- **Select changes in adjust mode.** A change of `select` takes effect on the next edge. It does not reset the blink counter.

## Test plan
All scenarios use SCAN_DIV=4 and BLINK_TICKS=2.

1. **Reset and scan order.** Hold reset 3 cycles with digits 1,2,3,4 (`min1..sec0`), then release.
   - `an/seg` must be 1111/1111111 during reset.
   - Then 1110/0011001 (4) for 4 cycles, 1101/0110000 (3), 1011/0100100 (2), 0111/1111001 (1), then repeat.
2. **Full decode.** Step `sec0` through 0..15 with `adjust=0`, checking `seg` in each idx-0 slot. Values 0–9 must match the table; 10–15 must give 1111111 with `an=1110`.
3. **Blink seconds.** Set `adjust=01`, `select=1`, digits 5,9,5,9.
   - idx 0/1 slots are visible for 8 cycles, then `an=1111` for the next 8 cycles.
   - Minutes slots are always visible.
   - The pattern alternates every 8 cycles.
4. **Blink minutes.** Same as scenario 3 with `select=0`: idx 2/3 blank in odd half-periods, and seconds are always visible.
5. **Adjust exit mid-blank.** While blanked, drop `adjust` to 0. The next cycle shows the digit normally, and a later re-entry starts in the visible phase for 8 cycles.
6. **Reset mid-operation.** Assert reset during idx 2. Outputs go to 1111/1111111 at the next edge, and after release the scan restarts at idx 0 with full 4-cycle slots.

Source files
------------

// File: rtl/display_mux.sv
`default_nettype none
// ============================================================================
// Module   : display_mux
// Purpose  : Scans four BCD digits onto a common-anode 7-segment display,
//            blinking the selected field while an adjust mode is active.
// Revision : 1.0 - initial release
// ============================================================================
module display_mux #(
    parameter int SCAN_DIV    = 100000,
    parameter int BLINK_TICKS = 250
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] min1,
    input  logic [3:0] min0,
    input  logic [3:0] sec1,
    input  logic [3:0] sec0,
    input  logic [1:0] adjust,
    input  logic       select,
    output logic [3:0] an,
    output logic [6:0] seg
);

    localparam int c_SCAN_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int c_BLINK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam logic [c_SCAN_W-1:0]  c_SCAN_MAX  = c_SCAN_W'(SCAN_DIV - 1);
    localparam logic [c_BLINK_W-1:0] c_BLINK_MAX = c_BLINK_W'(BLINK_TICKS - 1);

    logic [c_SCAN_W-1:0]  r_scan_cnt;
    logic [1:0]           r_idx;
    logic [c_BLINK_W-1:0] r_blink_cnt;
    logic                 r_blink_phase;

    logic       w_scan_tick;
    logic       w_adjusting;
    logic       w_blank;
    logic [3:0] w_digit;
    logic [3:0] w_an;
    logic [6:0] w_seg;

    assign w_scan_tick = (r_scan_cnt == c_SCAN_MAX);
    assign w_adjusting = (adjust != 2'b00);
    // select=1 owns the seconds slots (idx 0/1), select=0 the minutes (idx 2/3)
    assign w_blank     = w_adjusting && r_blink_phase && (select ? ~r_idx[1] : r_idx[1]);

    always_comb begin
        w_digit = sec0;
        w_an    = 4'b1110;
        case (r_idx)
            2'd0: begin w_digit = sec0; w_an = 4'b1110; end
            2'd1: begin w_digit = sec1; w_an = 4'b1101; end
            2'd2: begin w_digit = min0; w_an = 4'b1011; end
            2'd3: begin w_digit = min1; w_an = 4'b0111; end
            default: begin w_digit = sec0; w_an = 4'b1110; end
        endcase
    end

    always_comb begin
        w_seg = 7'b1111111;
        case (w_digit)
            4'd0: w_seg = 7'b1000000;
            4'd1: w_seg = 7'b1111001;
            4'd2: w_seg = 7'b0100100;
            4'd3: w_seg = 7'b0110000;
            4'd4: w_seg = 7'b0011001;
            4'd5: w_seg = 7'b0010010;
            4'd6: w_seg = 7'b0000010;
            4'd7: w_seg = 7'b1111000;
            4'd8: w_seg = 7'b0000000;
            4'd9: w_seg = 7'b0010000;
            default: w_seg = 7'b1111111;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_scan_cnt <= '0;
            r_idx      <= 2'd0;
        end else if (w_scan_tick) begin
            r_scan_cnt <= '0;
            r_idx      <= r_idx + 2'd1;
        end else begin
            r_scan_cnt <= r_scan_cnt + 1'b1;
        end
    end

    // Held clear outside adjust mode so every entry begins in the visible phase
    always_ff @(posedge clk) begin
        if (reset || !w_adjusting) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else if (w_scan_tick) begin
            if (r_blink_cnt == c_BLINK_MAX) begin
                r_blink_cnt   <= '0;
                r_blink_phase <= ~r_blink_phase;
            end else begin
                r_blink_cnt <= r_blink_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || w_blank) begin
            an  <= 4'b1111;
            seg <= 7'b1111111;
        end else begin
            an  <= w_an;
            seg <= w_seg;
        end
    end

endmodule
`default_nettype wire
